// File: rtl/enclave_cmd_frontend.sv
// Wishbone slave front-end for the LWE engine: scratchpad port, opcode push
// into a small command FIFO, status/control register and a one-at-a-time dispatcher.
module enclave_cmd_frontend #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 10,
    parameter int          DEPTH       = 1024,
    parameter int          OP_WIDTH    = 2,
    parameter int          CMD_DEPTH   = 4,
    parameter logic [31:0] OPCODE_ADDR = 32'h3000_0000,
    parameter logic [31:0] STATUS_ADDR = 32'h3000_0004
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  eng_start,
    output logic [OP_WIDTH-1:0]   eng_opcode,
    output logic [ADDR_WIDTH-1:0] eng_src0,
    output logic [ADDR_WIDTH-1:0] eng_src1,
    output logic [ADDR_WIDTH-1:0] eng_dst,
    input  logic                  eng_done,
    output logic                  irq_o
);

    localparam int               CMD_W     = OP_WIDTH + 3 * ADDR_WIDTH;
    localparam int               PTR_W     = $clog2(CMD_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [31:0]      MEM_LIMIT = 32'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CMD_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CMD_W-1:0]    fifo_q [CMD_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                overflow_q;
    logic [7:0]          done_cnt_q;
    logic                ack_q, rd_mem_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                eng_start_q, irq_q;
    logic [CMD_W-1:0]    eng_cmd_q;

    logic req_s, sel_mem_s, sel_op_s, sel_stat_s, mem_req_s, mem_go_s, wb_go_s;
    logic push_s, push_ok_s, pop_s, done_ev_s, full_s, empty_s, busy_s;
    logic clr_ovf_s, clr_done_s, unused_sel_s;
    logic [DATA_WIDTH-1:0] status_s;

    assign unused_sel_s = ^wbs_sel_i;

    assign req_s      = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign sel_mem_s  = (wbs_adr_i < MEM_LIMIT);
    assign sel_op_s   = (wbs_adr_i == OPCODE_ADDR);
    assign sel_stat_s = (wbs_adr_i == STATUS_ADDR);
    assign mem_req_s  = req_s & sel_mem_s;
    // Scratchpad traffic is parked (no mem_en, no ack) while a command is in flight.
    assign mem_go_s   = mem_req_s & ~busy_s;
    assign wb_go_s    = req_s & (~sel_mem_s | ~busy_s);
    assign full_s     = (count_q == CNT_FULL);
    assign empty_s    = (count_q == '0);
    assign push_s     = req_s & wbs_we_i & sel_op_s;
    assign push_ok_s  = push_s & (~full_s | pop_s);
    assign clr_ovf_s  = req_s & wbs_we_i & sel_stat_s & wbs_dat_i[3];
    assign clr_done_s = req_s & wbs_we_i & sel_stat_s & wbs_dat_i[31];

    assign mem_en    = mem_go_s;
    assign mem_we    = mem_go_s & wbs_we_i;
    assign mem_addr  = mem_go_s ? wbs_adr_i[ADDR_WIDTH-1:0] : '0;
    assign mem_wdata = (mem_go_s & wbs_we_i) ? wbs_dat_i : '0;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = ack_q ? (rd_mem_q ? mem_rdata : rdata_q) : '0;

    assign eng_start  = eng_start_q;
    assign irq_o      = irq_q;
    assign eng_opcode = eng_cmd_q[OP_WIDTH-1:0];
    assign eng_src0   = eng_cmd_q[OP_WIDTH +: ADDR_WIDTH];
    assign eng_src1   = eng_cmd_q[OP_WIDTH + ADDR_WIDTH +: ADDR_WIDTH];
    assign eng_dst    = eng_cmd_q[OP_WIDTH + 2 * ADDR_WIDTH +: ADDR_WIDTH];

    // Dispatch state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dispatch next state; a scratchpad request in its request cycle wins over issue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s && !mem_req_s) state_d = ST_ISSUE;
                else                        state_d = ST_IDLE;
            end
            ST_ISSUE: state_d = ST_RUN;
            ST_RUN: begin
                if (eng_done) state_d = ST_IDLE;
                else          state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Dispatch state decode.
    always_comb begin
        busy_s    = 1'b0;
        pop_s     = 1'b0;
        done_ev_s = 1'b0;
        case (state_q)
            ST_IDLE:  busy_s = 1'b0;
            ST_ISSUE: begin
                busy_s = 1'b1;
                pop_s  = 1'b1;
            end
            ST_RUN: begin
                busy_s    = 1'b1;
                done_ev_s = eng_done;
            end
            default: busy_s = 1'b0;
        endcase
    end

    // Status word assembly.
    always_comb begin
        status_s        = '0;
        status_s[0]     = busy_s;
        status_s[1]     = full_s;
        status_s[2]     = empty_s;
        status_s[3]     = overflow_q;
        status_s[8:4]   = 5'(count_q);
        status_s[23:16] = done_cnt_q;
    end

    // Command FIFO storage, pointers and occupancy.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int i = 0; i < CMD_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                fifo_q[wr_ptr_q] <= wbs_dat_i[CMD_W-1:0];
                wr_ptr_q         <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_ok_s, pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag and completion counter; software clears take priority.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            overflow_q <= 1'b0;
            done_cnt_q <= 8'd0;
        end else begin
            if (clr_ovf_s)                    overflow_q <= 1'b0;
            else if (push_s && full_s && !pop_s) overflow_q <= 1'b1;
            if (clr_done_s)     done_cnt_q <= 8'd0;
            else if (done_ev_s) done_cnt_q <= done_cnt_q + 8'd1;
        end
    end

    // Wishbone acknowledge and registered read data.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_q    <= 1'b0;
            rd_mem_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ack_q    <= wb_go_s;
            rd_mem_q <= wb_go_s & sel_mem_s & ~wbs_we_i;
            if (wb_go_s && !wbs_we_i && sel_stat_s) rdata_q <= status_s;
            else                                    rdata_q <= '0;
        end
    end

    // Engine handshake: start pulse, held command fields and completion irq.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            eng_start_q <= 1'b0;
            irq_q       <= 1'b0;
            eng_cmd_q   <= '0;
        end else begin
            eng_start_q <= pop_s;
            irq_q       <= done_ev_s;
            if (pop_s) eng_cmd_q <= fifo_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_enclave_cmd_frontend.sv
// Randomized self-checking bench for enclave_cmd_frontend against a queue-based
// model of the command flow, plus directed boundary scenarios.
module tb_enclave_cmd_frontend;

    localparam int          DW   = 32;
    localparam int          AW   = 10;
    localparam int          MD   = 1024;
    localparam int          OPW  = 2;
    localparam int          CD   = 4;
    localparam logic [31:0] OP_A = 32'h3000_0000;
    localparam logic [31:0] ST_A = 32'h3000_0004;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, stb, cyc, we, ack, mem_en, mem_we, eng_start, eng_done, irq;
    logic [3:0]     sel;
    logic [31:0]    adr;
    logic [DW-1:0]  dati, dato, mem_wdata, mem_rdata;
    logic [AW-1:0]  mem_addr, eng_src0, eng_src1, eng_dst;
    logic [OPW-1:0] eng_opcode;

    enclave_cmd_frontend #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(MD), .OP_WIDTH(OPW), .CMD_DEPTH(CD),
        .OPCODE_ADDR(OP_A), .STATUS_ADDR(ST_A)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dati), .wbs_ack_o(ack), .wbs_dat_o(dato),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .eng_start(eng_start), .eng_opcode(eng_opcode),
        .eng_src0(eng_src0), .eng_src1(eng_src1), .eng_dst(eng_dst), .eng_done(eng_done),
        .irq_o(irq)
    );

    // Scratchpad memory with one-cycle read latency.
    logic [DW-1:0] mem_arr [MD];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    // Event counters on DUT outputs.
    int          start_cnt = 0, irq_cnt = 0, memen_cnt = 0;
    logic [31:0] last_cmd  = 32'd0;
    always @(negedge clk) begin
        if (eng_start) begin
            start_cnt <= start_cnt + 1;
            last_cmd  <= {eng_dst, eng_src1, eng_src0, eng_opcode};
        end
        if (irq) irq_cnt <= irq_cnt + 1;
    end
    always @(posedge clk) if (mem_en) memen_cnt <= memen_cnt + 1;

    // Reference model state.
    logic [31:0] q [$];
    logic [31:0] shadow [int];
    int          waddrs [$];
    bit          running = 1'b0, ovf = 1'b0;
    logic [7:0]  done_cnt = 8'd0;
    int          exp_starts = 0, exp_irqs = 0;
    logic [31:0] exp_cmd = 32'd0;
    int          n_chk = 0, n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] mk_cmd(input logic [1:0] op, input logic [9:0] s0,
                                           input logic [9:0] s1, input logic [9:0] d);
        return {d, s1, s0, op};
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = 32'd0;
        s[0]     = running;
        s[1]     = (q.size() == CD);
        s[2]     = (q.size() == 0);
        s[3]     = ovf;
        s[8:4]   = 5'(q.size());
        s[23:16] = done_cnt;
        return s;
    endfunction

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        rd   = 32'd0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dati = d;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (ack) begin
                seen = 1'b1;
                rd   = dato;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = 32'd0; dati = 32'd0;
        check_val("wb_ack_seen", 32'(seen), 32'd1);
    endtask

    // After a quiet interval the dispatcher must have issued the next queued command.
    task automatic settle();
        tick(5);
        if (!running && q.size() > 0) begin
            running = 1'b1;
            exp_cmd = q.pop_front();
            exp_starts++;
        end
        check_val("start_cnt", 32'(start_cnt), 32'(exp_starts));
        check_val("irq_cnt", 32'(irq_cnt), 32'(exp_irqs));
        if (running) check_val("eng_cmd", last_cmd, exp_cmd);
    endtask

    task automatic m_memwr(input int a, input logic [31:0] d);
        logic [31:0] rd; int lat;
        wb_xfer(1'b1, 32'(a), d, rd, lat);
        check_val("mem_wr_lat", 32'(lat), 32'd1);
        if (!shadow.exists(a)) waddrs.push_back(a);
        shadow[a] = d;
    endtask

    task automatic m_memrd(input int a);
        logic [31:0] rd; int lat;
        wb_xfer(1'b0, 32'(a), 32'd0, rd, lat);
        check_val("mem_rd_data", rd, shadow[a]);
        check_val("mem_rd_lat", 32'(lat), 32'd1);
    endtask

    task automatic m_push(input logic [31:0] c);
        logic [31:0] rd; int lat;
        wb_xfer(1'b1, OP_A, c, rd, lat);
        if (q.size() == CD) ovf = 1'b1;
        else                q.push_back(c);
        settle();
    endtask

    task automatic m_done();
        @(negedge clk); eng_done = 1'b1;
        @(negedge clk); eng_done = 1'b0;
        if (running) begin
            running  = 1'b0;
            done_cnt = done_cnt + 8'd1;
            exp_irqs++;
        end
        settle();
    endtask

    task automatic m_status(input string tag);
        logic [31:0] rd; int lat;
        wb_xfer(1'b0, ST_A, 32'd0, rd, lat);
        check_val(tag, rd, exp_status());
    endtask

    task automatic m_statwr(input logic [31:0] d);
        logic [31:0] rd; int lat;
        wb_xfer(1'b1, ST_A, d, rd, lat);
        if (d[3])  ovf = 1'b0;
        if (d[31]) done_cnt = 8'd0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, c;
        logic [31:0] lo [6];
        logic [31:0] hi [6];
        int lat, m0, a, r;
        lo = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        hi = '{32'd2, 32'd3, 32'd4, 32'd4, 32'd4, 32'd4};
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
        adr = 32'd0; dati = 32'd0; eng_done = 1'b0;
        tick(3);
        check_val("rst_ack", 32'(ack), 32'd0);
        check_val("rst_start", 32'(eng_start), 32'd0);
        rst_n = 1'b1;
        tick(2);
        m_status("status_reset");

        // Scratchpad write/read-back.
        m0 = memen_cnt;
        for (int i = 0; i < 6; i++) begin
            m_memwr(i, lo[i]);
            m_memwr(100 + i, hi[i]);
        end
        tick(1);
        check_val("ack_single", 32'(ack), 32'd0);
        check_val("mem_en_writes", 32'(memen_cnt - m0), 32'd12);
        check_val("mem_arr_0", mem_arr[0], 32'd1);
        check_val("mem_arr_101", mem_arr[101], 32'd3);
        for (int i = 0; i < 6; i++) begin
            m_memrd(i);
            m_memrd(100 + i);
        end

        // Single command: start latency and field hold.
        c = mk_cmd(2'd0, 10'd0, 10'd100, 10'd50);
        wb_xfer(1'b1, OP_A, c, rd, lat);
        q.push_back(c);
        tick(1);
        check_val("start_lat_early", 32'(eng_start), 32'd0);
        tick(1);
        check_val("start_lat", 32'(eng_start), 32'd1);
        check_val("eng_src1", 32'(eng_src1), 32'd100);
        check_val("eng_dst", 32'(eng_dst), 32'd50);
        settle();
        m_status("status_busy");
        m_done();
        m_status("status_done1");

        // Queue fill and overflow.
        for (int i = 0; i < 5; i++) m_push(mk_cmd(2'(i), 10'(i + 1), 10'(i + 7), 10'(i + 9)));
        m_status("status_full");
        m_push(mk_cmd(2'd3, 10'd1, 10'd2, 10'd3));
        m_status("status_ovf");
        m_statwr(32'h0000_0008);
        m_status("status_ovf_clr");
        for (int i = 0; i < 5; i++) m_done();
        m_status("status_drained");

        // Scratchpad read stalled by a running command.
        m_memwr(50, 32'd30);
        m_push(mk_cmd(2'd1, 10'd3, 10'd4, 10'd5));
        m0 = memen_cnt;
        fork
            wb_xfer(1'b0, 32'd50, 32'd0, rd, lat);
            begin
                repeat (6) @(negedge clk);
                eng_done = 1'b1;
                @(negedge clk);
                eng_done = 1'b0;
            end
        join
        running = 1'b0; done_cnt = done_cnt + 8'd1; exp_irqs++;
        check_val("stall_lat", 32'(lat), 32'd7);
        check_val("stall_data", rd, 32'd30);
        check_val("stall_mem_en", 32'(memen_cnt - m0), 32'd1);
        settle();

        // Stray done and unmapped/opcode reads.
        m_done();
        m_status("status_stray_done");
        wb_xfer(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, rd, lat);
        wb_xfer(1'b0, 32'h2000_0000, 32'd0, rd, lat);
        check_val("unmapped_rd", rd, 32'd0);
        wb_xfer(1'b0, OP_A, 32'd0, rd, lat);
        check_val("opcode_rd", rd, 32'd0);

        // Reset while running with two queued.
        for (int i = 0; i < 3; i++) m_push(mk_cmd(2'd3, 10'h3FF, 10'h155, 10'h2AA));
        m_status("status_pre_rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_run_fields", {eng_dst, eng_src1}, 32'd0);
        check_val("rst_run_src0_op", {eng_src0, eng_opcode, eng_start, irq}, 32'd0);
        check_val("rst_run_wb", {ack, mem_en, mem_we, mem_addr}, 32'd0);
        check_val("rst_run_dato", dato, 32'd0);
        q.delete(); running = 1'b0; ovf = 1'b0; done_cnt = 8'd0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        m_status("status_post_rst");
        m_done();
        m_status("status_post_rst_done");

        // Completion counter wrap.
        for (int i = 0; i < 256; i++) begin
            m_push(32'(i));
            m_done();
            if (i == 254) m_status("status_cnt255");
        end
        m_status("status_cnt_wrap");

        // Randomized traffic.
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 7);
            case (r)
                0, 1: begin
                    if (!running) m_memwr($urandom_range(0, MD - 1), $urandom);
                    else          m_done();
                end
                2: begin
                    if (!running) begin
                        a = waddrs[$urandom_range(0, waddrs.size() - 1)];
                        m_memrd(a);
                    end else begin
                        m_done();
                    end
                end
                3, 4: m_push($urandom);
                5: m_done();
                6: m_status("status_rand");
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        m_statwr($urandom & 32'h8000_00FF);
                    end else begin
                        wb_xfer($urandom_range(0, 1) == 1, 32'h4000_0000 + 32'($urandom_range(0, 255)),
                                $urandom, rd, lat);
                        check_val("rand_unmapped", rd, 32'd0);
                    end
                end
            endcase
        end
        while (running) m_done();
        m_status("status_final");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/enclave_cmd_frontend.md
Name: enclave_cmd_frontend

Overview:
Wishbone slave front-end for the LWE encryption engine. It replaces the single-opcode register with a parametrised command queue, and maps wishbone traffic onto three targets:
- a scratchpad memory port (ciphertext/key words),
- an opcode push address,
- a status/control register.
A dispatch FSM pops queued commands and handshakes them to the compute engine one at a time. Wishbone memory access is held off while a command runs.

Parameters:
- DATA_WIDTH, 32, wishbone data width.
- ADDR_WIDTH, 10, scratchpad address width and width of each operand field in a command.
- DEPTH, 1024, scratchpad words; wishbone addresses 0..DEPTH-1 map to memory.
- OP_WIDTH, 2, opcode field width; OP_WIDTH+3*ADDR_WIDTH <= DATA_WIDTH.
- CMD_DEPTH, 4, command FIFO entries (power of two, 2..16).
- OPCODE_ADDR, 32'h30000000, write-only command push address.
- STATUS_ADDR, 32'h30000004, status/control register address.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; asynchronous, active-low.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  wishbone strobe, cycle, write-enable.
- wbs_sel_i  in  4  byte select; all-ones required, other values are treated as all-ones.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  DATA_WIDTH  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  DATA_WIDTH  read data.
- mem_en  out  1  scratchpad access enable.
- mem_we  out  1  scratchpad write enable.
- mem_addr  out  ADDR_WIDTH  scratchpad address.
- mem_wdata  out  DATA_WIDTH  scratchpad write data.
- mem_rdata  in  DATA_WIDTH  scratchpad read data; valid 1 cycle after mem_en with mem_we=0.
- eng_start  out  1  one-cycle start pulse.
- eng_opcode  out  OP_WIDTH  command opcode.
- eng_src0, eng_src1, eng_dst  out  ADDR_WIDTH  command operand addresses.
- eng_done  in  1  one-cycle completion pulse.
- irq_o  out  1  one-cycle pulse per completed command.

Behaviour:
- Reset (wb_rst_i low, async): all outputs 0, FIFO empty, FSM IDLE, overflow=0, done_cnt=0.
- Command word packing:
  - [OP_WIDTH-1:0] opcode
  - next ADDR_WIDTH bits src0
  - next ADDR_WIDTH bits src1
  - next ADDR_WIDTH bits dst
  - remaining upper bits ignored.
- Wishbone handshake: a request is stb&cyc&~ack. wbs_ack_o is a single-cycle pulse; wbs_dat_o is valid in the ack cycle and 0 otherwise.
- Memory write (address < DEPTH, FSM IDLE): mem_en=mem_we=1 in the request cycle with mem_addr=adr[ADDR_WIDTH-1:0]; ack next cycle.
- Memory read (FSM IDLE): mem_en=1, mem_we=0 in the request cycle; ack next cycle with wbs_dat_o=mem_rdata.
- Memory access while FSM not IDLE: ack withheld and no mem_en until the FSM returns to IDLE; the request is then serviced as above.
- OPCODE_ADDR write: push the command; ack next cycle.
  - If FIFO full and no pop in the same cycle: command dropped, overflow set (sticky), ack still issued.
  - Push and pop in the same cycle while full: push accepted.
  - OPCODE_ADDR read returns 0.
- STATUS_ADDR read:
  - bit0 busy (FSM != IDLE)
  - bit1 full
  - bit2 empty
  - bit3 overflow
  - bits[8:4] count
  - bits[23:16] done_cnt
  - other bits 0.
- STATUS_ADDR write: bit3=1 clears overflow; bit31=1 clears done_cnt. Always acked next cycle.
- Any other address: ack next cycle; read returns 0; write ignored.
- FSM states and transitions:
  - IDLE -> ISSUE when FIFO non-empty and no memory access is in its request cycle.
  - ISSUE: pop the head; eng_start=1 for exactly one cycle; eng_* fields hold the popped command until the next ISSUE; go to RUN.
  - RUN: wait for eng_done. On done: done_cnt+1 (8-bit wrap 255->0), irq_o=1 for one cycle, go to IDLE.
- Dispatch latency: 1 cycle minimum from IDLE to eng_start. Back-to-back commands have at least one IDLE cycle between done and the next start.
- eng_done outside RUN: ignored (not counted, no irq).
- Reset mid-RUN: FSM returns to IDLE, queued commands lost, later eng_done ignored.
- FIFO pointers wrap modulo CMD_DEPTH; count ranges 0..CMD_DEPTH.

Test Plan:
- Write 1,0,0,0,0,0 to mem 0..5 and 2,3,4,4,4,4 to mem 100..105; read back -> mem_we pulses at addresses 0..5 and 100..105 with correct data, each ack exactly one cycle, read acks return the stored values.
- Push command opcode=0, src0=0, src1=100, dst=50 -> eng_start pulse 2 cycles after the push ack with eng_src1=100 and eng_dst=50; status busy=1 until eng_done, then done_cnt=1 and one irq_o pulse.
- Hold eng_done off, push 5 commands with CMD_DEPTH=4 -> first dispatched, 4 queued, no drop; 6th push sets overflow=1 and count stays 4; writing status bit3 clears overflow.
- Memory read of address 50 issued during RUN -> no ack until after eng_done; then ack with mem_rdata (e.g. 30).
- Pulse eng_done in IDLE -> done_cnt unchanged, no irq; access to 32'h20000000 -> acked, reads 0.
- Assert reset during RUN with 2 queued -> all outputs 0 immediately; status after release reads empty=1, count=0, busy=0.
